// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters; full 8-bit frames.
// Optional grant locking across frames is compiled in with `define SPI_BURST_EN.
module spi_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_GAP   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     lock,
  input  logic [8*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 ss,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAXC = (CLK_DIV > SS_SETUP) ? ((CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP)
                                             : ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP);
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(SS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, BIT_LO, BIT_HI, TAIL, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [7:0]       tx_reg, tx_next;
  logic [7:0]       rx_reg, rx_next;
  logic [2:0]       bit_reg, bit_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic             burst_reg, burst_next;
  logic [N_REQ-1:0] done_reg;
  logic [7:0]       rdata_reg;
  logic             ss_reg, sck_reg, mosi_reg;
  logic             miso_s1, miso_s2;
  logic [IW-1:0]    win_idx;
  logic [IW:0]      sum;
  logic             frame_end;

  logic [7:0] wbyte [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wbyte
    assign wbyte[gi] = wdata[8*gi +: 8];
  end

`ifndef SPI_BURST_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Scan downwards so the requester closest at-or-after ptr is the last writer.
  always_comb begin
    win_idx = ptr_reg;
    sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_reg} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (req[sum[IW-1:0]]) win_idx = sum[IW-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    bit_next   = bit_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    gnt_next   = gnt_reg;
    burst_next = burst_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (burst_reg) begin
          tx_next    = wbyte[owner_reg];
          rx_next    = '0;
          bit_next   = '0;
          burst_next = 1'b0;
          state_next = SETUP;
        end else if (|req) begin
          tx_next    = wbyte[win_idx];
          rx_next    = '0;
          bit_next   = '0;
          owner_next = win_idx;
          gnt_next   = N_REQ'(1) << win_idx;
          ptr_next   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: if (cnt_reg == SETUP_LAST) begin
        cnt_next   = '0;
        state_next = BIT_LO;
      end
      BIT_LO: if (cnt_reg == DIV_LAST) begin
        rx_next[bit_reg] = miso_s2;
        cnt_next         = '0;
        state_next       = BIT_HI;
      end
      BIT_HI: if (cnt_reg == DIV_LAST) begin
        tx_next    = {tx_reg[6:0], 1'b0};
        bit_next   = bit_reg + 3'd1;
        cnt_next   = '0;
        state_next = (bit_reg == 3'd7) ? TAIL : BIT_LO;
      end
      TAIL: if (cnt_reg == DIV_LAST) begin
        cnt_next   = '0;
        state_next = GAP;
      end
      GAP: if (cnt_reg == GAP_LAST) begin
        cnt_next   = '0;
        state_next = IDLE;
`ifdef SPI_BURST_EN
        if (|(gnt_reg & lock & req)) burst_next = 1'b1;
        else                         gnt_next   = '0;
`else
        gnt_next = '0;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // done and rdata change together on the edge into the final GAP cycle.
  assign frame_end = (state_next == GAP) && (cnt_next == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      bit_reg   <= '0;
      ptr_reg   <= '0;
      owner_reg <= '0;
      gnt_reg   <= '0;
      burst_reg <= 1'b0;
      done_reg  <= '0;
      rdata_reg <= '0;
      ss_reg    <= 1'b1;
      sck_reg   <= 1'b0;
      mosi_reg  <= 1'b0;
      miso_s1   <= 1'b0;
      miso_s2   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      bit_reg   <= bit_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      gnt_reg   <= gnt_next;
      burst_reg <= burst_next;
      done_reg  <= frame_end ? gnt_reg : '0;
      if (frame_end) rdata_reg <= rx_reg;
      ss_reg    <= !(state_next inside {SETUP, BIT_LO, BIT_HI, TAIL});
      sck_reg   <= (state_next == BIT_HI);
      mosi_reg  <= (state_next inside {BIT_LO, BIT_HI}) ? tx_next[7] : 1'b0;
      miso_s1   <= miso;
      miso_s2   <= miso_s1;
    end
  end

  assign gnt   = gnt_reg;
  assign done  = done_reg;
  assign rdata = rdata_reg;
  assign busy  = (state_reg != IDLE);
  assign ss    = ss_reg;
  assign sck   = sck_reg;
  assign mosi  = mosi_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: vector table, corner sequences and randomized frames vs a round-robin model.
// Build with +define+SPI_BURST_EN to exercise the grant-lock sequence.
module tb_spi_bus_arbiter;
  localparam int N        = 4;
  localparam int CLK_DIV  = 4;
  localparam int SS_SETUP = 2;
  localparam int SS_GAP   = 2;
  localparam int LAT      = 1 + SS_SETUP + 17*CLK_DIV + SS_GAP - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0, lock = '0;
  logic [8*N-1:0] wdata = '0;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rdata;
  logic           busy, ss, sck, mosi, miso;

  spi_bus_arbiter #(.N_REQ(N), .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .SS_GAP(SS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Behavioural slave: din latched on ss fall, MISO LSB-first, MOSI MSB-first, dout on ss rise.
  logic [7:0] slave_din = '0, sl_din_lat = '0, sl_sh = '0, sl_dout = '0;
  int sl_idx = 0, sck_rises = 0, sck_bad = 0, ss_run = 0, last_ss_run = 0;
  always @(negedge ss) begin sl_din_lat = slave_din; sl_idx = 0; sl_sh = '0; end
  always @(posedge ss) sl_dout = sl_sh;
  always @(posedge sck) begin
    sl_sh = {sl_sh[6:0], mosi};
    sck_rises++;
    if (ss !== 1'b0) sck_bad++;
  end
  always @(negedge sck) sl_idx++;
  assign miso = sl_din_lat[sl_idx[2:0]];

  always @(negedge clk) begin
    if (ss === 1'b1) ss_run++;
    else begin
      if (ss_run > 0) last_ss_run = ss_run;
      ss_run = 0;
    end
  end

  int n_tests = 0, n_fail = 0;
  logic [N-1:0] first_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output logic [N-1:0] dv, output int cyc);
    cyc = 0;
    dv  = '0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (first_gnt == '0 && gnt != '0) first_gnt = gnt;
      if (done != '0) begin dv = done; break; end
    end
    if (dv == '0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
  endtask

  task automatic wait_gnt();
    int k = 0;
    while (gnt == '0 && k < 20) begin @(negedge clk); k++; end
    if (gnt == '0) begin
      n_tests++; n_fail++;
      $display("FAIL gnt_timeout: gnt still %b", gnt);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference arbitration rule: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic [31:0]  wd;
    logic [7:0]   din;
    logic [N-1:0] exp_gnt;
    logic [7:0]   exp_dout;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [N-1:0] dv;
    int cyc, w, mptr;
    logic [N-1:0] seq_a [6];
    logic [N-1:0] m;
    logic [31:0] wd;
    logic [7:0] din;

    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] dv;
    int cyc, w, mptr, k;
    logic [N-1:0] seq_a [6];
    logic [N-1:0] m;
    logic [31:0] wd;
    logic [7:0] din;
`ifdef SPI_BURST_EN
    logic [N-1:0] seq_d [4];
    int nd = 4;
`else
    logic [N-1:0] seq_d [2];
    int nd = 2;
`endif

    tbl[0] = '{4'b0001, 32'h443322A5, 8'h3C, 4'b0001, 8'hA5};
    tbl[1] = '{4'b0001, 32'h0000005A, 8'hC3, 4'b0001, 8'h5A};
    tbl[2] = '{4'b1001, 32'h81000018, 8'h96, 4'b1000, 8'h81};
    tbl[3] = '{4'b0110, 32'h00E77E00, 8'h01, 4'b0010, 8'h7E};
    tbl[4] = '{4'b0011, 32'h0000F00F, 8'h80, 4'b0001, 8'h0F};
    tbl[5] = '{4'b1111, 32'h12345678, 8'h55, 4'b0010, 8'h56};
    tbl[6] = '{4'b0100, 32'h00FF0000, 8'hFF, 4'b0100, 8'hFF};
    tbl[7] = '{4'b0100, 32'h00240000, 8'h00, 4'b0100, 8'h24};

    // Reset state
    @(negedge clk);
    check("rst_ss", ss, 1); check("rst_sck", sck, 0); check("rst_mosi", mosi, 0);
    check("rst_gnt", gnt, 0); check("rst_done", done, 0); check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four held: 0,1,2,3 then only 0 and 2 remain
    seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
    req = 4'b1111; wdata = 32'h44332211; first_gnt = '0;
    for (int f = 0; f < 6; f++) begin
      wait_done(dv, cyc);
      $display("[TB] rr frame %0d done=%b cycles=%0d", f, dv, cyc);
      check("rr_order", dv, seq_a[f]);
      if (f == 0) check("rr_latency", cyc, LAT);
      else if (f != 3) check("rr_back2back", cyc, LAT + 1);
      if (f == 2) begin
        repeat (3) @(negedge clk);
        req = 4'b0101;
      end
    end
    req = '0;
    @(negedge clk);

    // Vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wdata = tbl[i].wd; slave_din = tbl[i].din; first_gnt = '0; sck_rises = 0;
      req = tbl[i].req;
      wait_done(dv, cyc);
      check("vec_gnt", first_gnt, tbl[i].exp_gnt);
      check("vec_done", dv, tbl[i].exp_gnt);
      check("vec_latency", cyc, LAT);
      check("vec_rdata", rdata, tbl[i].din);
      check("vec_sck_rises", sck_rises, 8);
      req = '0;
      @(negedge clk);
      check("vec_dout", sl_dout, tbl[i].exp_dout);
      check("vec_idle_busy", busy, 0);
      check("vec_rdata_held", rdata, tbl[i].din);
      $display("[TB] vec %0d gnt=%b rdata=%h dout=%h cycles=%0d", i, first_gnt, rdata, sl_dout, cyc);
    end

    // req[1] dropped and wdata changed after grant
    req = 4'b0010; wdata = 32'h00006B00; slave_din = 8'h9D; first_gnt = '0;
    wait_gnt();
    req = '0; wdata = 32'h0000FF00;
    wait_done(dv, cyc);
    check("drop_done", dv, 4'b0010);
    check("drop_rdata", rdata, 8'h9D);
    @(negedge clk);
    check("drop_dout", sl_dout, 8'h6B);
    $display("[TB] drop-req frame done=%b rdata=%h dout=%h", dv, rdata, sl_dout);

    // Reset asserted during BIT_HI of bit 4
    req = 4'b0001; wdata = 32'h000000A5; slave_din = 8'h3C; sck_rises = 0;
    k = 0;
    while (!(sck_rises == 5 && sck === 1'b1) && k < 200) begin @(negedge clk); k++; end
    check("rst_mid_reached", sck_rises, 5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ss", ss, 1); check("rst_mid_sck", sck, 0);
    check("rst_mid_gnt", gnt, 0); check("rst_mid_busy", busy, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0001; wdata = 32'h000000C7; slave_din = 8'h2E; first_gnt = '0; sck_rises = 0;
    wait_done(dv, cyc);
    check("post_rst_done", dv, 4'b0001);
    check("post_rst_latency", cyc, LAT);
    check("post_rst_rdata", rdata, 8'h2E);
    check("post_rst_sck_rises", sck_rises, 8);
    req = '0;
    @(negedge clk);
    check("post_rst_dout", sl_dout, 8'hC7);
    $display("[TB] post-reset frame done=%b rdata=%h dout=%h", dv, rdata, sl_dout);

    // Lock on requester 2 with requester 1 waiting
`ifdef SPI_BURST_EN
    seq_d = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};
`else
    seq_d = '{4'b0100, 4'b0010};
`endif
    wdata = 32'h00B2C100; slave_din = 8'h5A;
    req = 4'b0100; lock = 4'b0100;
    wait_gnt();
    req = 4'b0110;
    for (int f = 0; f < nd; f++) begin
      wait_done(dv, cyc);
      $display("[TB] lock frame %0d done=%b ss_high_run=%0d", f, dv, last_ss_run);
      check("lock_order", dv, seq_d[f]);
      if (f >= 1) check("lock_ss_gap", (last_ss_run >= SS_GAP), 1);
`ifdef SPI_BURST_EN
      if (f == 1) begin
        repeat (3) @(negedge clk);
        lock = '0;
      end
`endif
    end
    req = '0; lock = '0;
    @(negedge clk);

    // Randomized frames against the round-robin model
    do_reset();
    mptr = 0;
    for (int t = 0; t < 25; t++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      wd = $urandom;
      din = 8'($urandom);
      wdata = wd; slave_din = din; first_gnt = '0;
      req = m;
      wait_done(dv, cyc);
      w = rr_pick(m, mptr);
      mptr = (w + 1) % N;
      check("rnd_done", dv, N'(1) << w);
      check("rnd_gnt", first_gnt, N'(1) << w);
      check("rnd_latency", cyc, LAT);
      check("rnd_rdata", rdata, din);
      req = '0;
      @(negedge clk);
      check("rnd_dout", sl_dout, wd[8*w +: 8]);
      $display("[TB] rnd %0d req=%b winner=%0d wdata=%h din=%h rdata=%h dout=%h", t, m, w, wd, din, rdata, sl_dout);
    end

    check("sck_while_ss_high", sck_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
